// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Fetches 32-bit instruction words from instruction memory using a
// request/response handshake. The fetched word is held in an instruction
// register. Opcode and Funct are decoded from that register for top_control.
// A resolved taken branch redirects the PC.
//
// Ports
//   clk, reset          system clock; asynchronous active-high reset
//   imem_req/imem_addr  one-cycle fetch request and its address
//   imem_rvalid/rdata   one-cycle response strobe and instruction word
//   stall               downstream not ready; hold the presented instruction
//   branch_taken/target redirect for the presented instruction
//   Instruction         instruction register
//   Opcode, Funct       fields decoded from Instruction
//   PC_out              address of the presented instruction
//   instr_valid         presented instruction outputs are valid
//   illegal_instr       presented opcode is not a supported class
//
// state | meaning
// ------+--------------------------------------------------------------
// FETCH | present a request (req_q=1) for pc_q, then move to WAIT
// WAIT  | wait for imem_rvalid, then load the instruction register
// ISSUE | present the instruction; advance or redirect when stall drops
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter int                    ADDR_WIDTH = 64,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_rvalid,
    input  logic [31:0]           imem_rdata,
    input  logic                  stall,
    input  logic                  branch_taken,
    input  logic [ADDR_WIDTH-1:0] branch_target,
    output logic [31:0]           Instruction,
    output logic [6:0]            Opcode,
    output logic [3:0]            Funct,
    output logic [ADDR_WIDTH-1:0] PC_out,
    output logic                  instr_valid,
    output logic                  illegal_instr
);

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        ISSUE = 2'd2
    } state_t;

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] pc_q;
    logic [ADDR_WIDTH-1:0] pc_out_q;
    logic [31:0]           instr_q;
    logic                  valid_q;
    logic                  req_q;

    // req_q is a registered output. After reset, FETCH spends one cycle
    // raising req_q, so the first request appears in the first clock after
    // reset is released. When ISSUE advances, it raises req_q on the way
    // into FETCH. FETCH then lasts exactly one cycle, which gives three
    // cycles per instruction at a memory latency of one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= FETCH;
            pc_q     <= RESET_PC;
            pc_out_q <= '0;
            instr_q  <= NOP_INSTR;
            valid_q  <= 1'b0;
            req_q    <= 1'b0;
        end else begin
            case (state_q)
                FETCH: begin
                    if (req_q) begin
                        req_q   <= 1'b0;
                        state_q <= WAIT;
                    end else begin
                        req_q   <= 1'b1;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        instr_q  <= imem_rdata;
                        pc_out_q <= pc_q;
                        pc_q     <= pc_q + ADDR_WIDTH'(4);
                        valid_q  <= 1'b1;
                        state_q  <= ISSUE;
                    end
                end
                ISSUE: begin
                    // A branch_taken seen during a stall is ignored. The
                    // branch unit holds it until stall drops.
                    if (!stall) begin
                        valid_q <= 1'b0;
                        req_q   <= 1'b1;
                        state_q <= FETCH;
                        if (branch_taken) begin
                            pc_q <= branch_target & ~ADDR_WIDTH'(3);
                        end
                    end
                end
                default: begin
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                    state_q <= FETCH;
                end
            endcase
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign Instruction = instr_q;
    assign PC_out      = pc_out_q;
    assign instr_valid = valid_q;
    assign Opcode      = instr_q[6:0];
    assign Funct       = {instr_q[30], instr_q[14:12]};

    always_comb begin
        illegal_instr = 1'b0;
        case (instr_q[6:0])
            7'b0110011,
            7'b0010011,
            7'b0000011,
            7'b0100011,
            7'b1100011: illegal_instr = 1'b0;
            default:    illegal_instr = valid_q;
        endcase
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit. Inputs are driven, and outputs
// sampled, 1 ns after each rising edge.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        branch_taken;
    logic [63:0] branch_target;
    logic [31:0] Instruction;
    logic [6:0]  Opcode;
    logic [3:0]  Funct;
    logic [63:0] PC_out;
    logic        instr_valid;
    logic        illegal_instr;

    int n_checks = 0;
    int n_fail   = 0;

    instr_fetch_unit #(.ADDR_WIDTH(64), .RESET_PC(64'h0)) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .Instruction   (Instruction),
        .Opcode        (Opcode),
        .Funct         (Funct),
        .PC_out        (PC_out),
        .instr_valid   (instr_valid),
        .illegal_instr (illegal_instr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called in the cycle where a request is visible. Returns the word after
    // lat cycles and leaves the bench in the first ISSUE cycle.
    task automatic serve(input int lat, input logic [31:0] data);
        step();
        for (int i = 1; i < lat; i++) begin
            check("no_rereq_in_wait", 64'(imem_req), 64'd0);
            step();
        end
        imem_rvalid = 1'b1;
        imem_rdata  = data;
        step();
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
    endtask

    task automatic check_present(input string tag, input logic [31:0] ins, input logic [6:0] op,
                                 input logic [3:0] fn, input logic [63:0] pc, input logic ill);
        check({tag, "_valid"}, 64'(instr_valid), 64'd1);
        check({tag, "_instr"}, 64'(Instruction), 64'(ins));
        check({tag, "_opcode"}, 64'(Opcode), 64'(op));
        check({tag, "_funct"}, 64'(Funct), 64'(fn));
        check({tag, "_pc_out"}, PC_out, pc);
        check({tag, "_illegal"}, 64'(illegal_instr), 64'(ill));
        check({tag, "_req_low"}, 64'(imem_req), 64'd0);
    endtask

    task automatic check_req(input string tag, input logic [63:0] addr);
        check({tag, "_req"}, 64'(imem_req), 64'd1);
        check({tag, "_addr"}, imem_addr, addr);
    endtask

    initial begin
        reset = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0;
        stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
        step();
        step();
        check("rst_instr", 64'(Instruction), 64'h13);
        check("rst_pc_out", PC_out, 64'h0);
        check("rst_req", 64'(imem_req), 64'd0);
        check("rst_valid", 64'(instr_valid), 64'd0);
        check("rst_illegal", 64'(illegal_instr), 64'd0);

        reset = 1'b0;
        check("c0_req", 64'(imem_req), 64'd0);
        step();
        check_req("c1", 64'h0);

        // add at 0, latency 1: valid at cycle 3
        serve(1, 32'h00B50533);
        check_present("add", 32'h00B50533, 7'b0110011, 4'b0000, 64'h0, 1'b0);
        step();
        check_req("after_add", 64'h4);
        check("valid_drop", 64'(instr_valid), 64'd0);

        // sub at 4
        serve(1, 32'h40B50533);
        check_present("sub", 32'h40B50533, 7'b0110011, 4'b1000, 64'h4, 1'b0);
        step();
        check_req("after_sub", 64'h8);

        // beq at 8 with a 4-cycle stall and a pending branch
        serve(1, 32'h00000063);
        check_present("beq", 32'h00000063, 7'b1100011, 4'b0000, 64'h8, 1'b0);
        stall = 1'b1; branch_taken = 1'b1; branch_target = 64'h103;
        for (int i = 0; i < 4; i++) begin
            step();
            check_present("beq_stall", 32'h00000063, 7'b1100011, 4'b0000, 64'h8, 1'b0);
        end
        stall = 1'b0;
        step();
        branch_taken = 1'b0; branch_target = '0;
        check_req("branch", 64'h100);

        // ld at 0x100 with a 5-cycle latency
        serve(5, 32'h00053283);
        check_present("ld", 32'h00053283, 7'b0000011, 4'b0011, 64'h100, 1'b0);
        step();
        check_req("after_ld", 64'h104);

        // unsupported opcode
        serve(1, 32'h0000007F);
        check_present("illeg", 32'h0000007F, 7'b1111111, 4'b0000, 64'h104, 1'b1);
        step();
        check_req("after_illeg", 64'h108);
        check("illeg_clear", 64'(illegal_instr), 64'd0);

        // branch to the top of the address space, then PC+4 wraps to 0
        serve(1, 32'h00000063);
        check_present("beq2", 32'h00000063, 7'b1100011, 4'b0000, 64'h108, 1'b0);
        branch_taken = 1'b1; branch_target = 64'hFFFF_FFFF_FFFF_FFFF;
        step();
        branch_taken = 1'b0; branch_target = '0;
        check_req("top", 64'hFFFF_FFFF_FFFF_FFFC);
        serve(1, 32'h00000013);
        check_present("top_nop", 32'h00000013, 7'b0010011, 4'b0000, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
        step();
        check_req("wrap", 64'h0);

        // reset during WAIT, then a late response just after release
        step();
        reset = 1'b1;
        step();
        check("rst2_instr", 64'(Instruction), 64'h13);
        check("rst2_valid", 64'(instr_valid), 64'd0);
        check("rst2_req", 64'(imem_req), 64'd0);
        check("rst2_pc_out", PC_out, 64'h0);
        reset = 1'b0;
        step();
        check_req("rst2_c1", 64'h0);
        imem_rvalid = 1'b1; imem_rdata = 32'hDEADBEEF;
        step();
        imem_rvalid = 1'b0; imem_rdata = '0;
        check("late_valid", 64'(instr_valid), 64'd0);
        check("late_instr", 64'(Instruction), 64'h13);
        check("late_req", 64'(imem_req), 64'd0);
        imem_rvalid = 1'b1; imem_rdata = 32'h00B50533;
        step();
        imem_rvalid = 1'b0; imem_rdata = '0;
        check_present("refetch", 32'h00B50533, 7'b0110011, 4'b0000, 64'h0, 1'b0);
        step();
        check_req("refetch_next", 64'h4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Producer side of the main/ALU control decode interface.
- Fetches 32-bit RV64 instruction words from instruction memory over a request/response handshake and holds the current instruction in an instruction register.
- Extracts and presents Opcode and Funct to top_control, and redirects the PC on a resolved branch.
- Sits between instruction memory and top_control in the single-issue datapath.

Parameters:
- ADDR_WIDTH, 64, width of PC and instruction-memory address.
- RESET_PC, 64'h0, PC loaded on reset.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- imem_req  output  1  one-cycle fetch request pulse
- imem_addr  output  ADDR_WIDTH  fetch address, valid while imem_req=1
- imem_rvalid  input  1  response strobe, one cycle, any latency >=1 after request
- imem_rdata  input  32  instruction word, valid with imem_rvalid
- stall  input  1  downstream not ready; holds the current instruction
- branch_taken  input  1  branch resolved taken for the presented instruction
- branch_target  input  ADDR_WIDTH  redirect address
- Instruction  output  32  instruction register
- Opcode  output  7  Instruction[6:0]
- Funct  output  4  {Instruction[30], Instruction[14:12]}
- PC_out  output  ADDR_WIDTH  address of the presented instruction
- instr_valid  output  1  Instruction/Opcode/Funct/PC_out are valid
- illegal_instr  output  1  presented opcode is not a supported class

Behaviour:
- Reset (async, any state):
  - State FETCH, PC=RESET_PC.
  - Instruction=32'h00000013 (nop), PC_out=0.
  - imem_req, instr_valid and illegal_instr all 0.
- FSM states: FETCH, WAIT, ISSUE.
- FETCH:
  - imem_req=1, imem_addr=PC, for exactly one cycle.
  - Next state WAIT.
  - The first request occurs in the first clock after reset deasserts.
- WAIT:
  - imem_req=0.
  - On imem_rvalid: Instruction<=imem_rdata, PC_out<=PC, PC<=PC+4 (wraps modulo 2^ADDR_WIDTH), instr_valid<=1; next state ISSUE.
  - imem_rvalid in FETCH or ISSUE is ignored.
- ISSUE:
  - instr_valid=1; all outputs held stable while stall=1.
  - stall=0 and branch_taken=0: advance; next state FETCH with the sequential PC.
  - stall=0 and branch_taken=1: PC<=branch_target with bits [1:0] forced to 0; next state FETCH.
  - branch_taken while stall=1 is ignored. The branch unit must hold it until stall drops.
  - instr_valid deasserts on the cycle after leaving ISSUE.
- Throughput: 3 cycles per instruction at 1-cycle memory latency with no stalls.
- Opcode and Funct are combinational from the instruction register, so they change only when Instruction loads.
- illegal_instr is combinational, qualified by instr_valid.
  - Supported opcodes: 0110011 (R), 0010011 (I-ALU), 0000011 (load), 0100011 (store), 1100011 (SB).
  - Any other opcode with instr_valid=1 sets illegal_instr=1. Fetch behaviour is unchanged.
- Reset mid-WAIT: a late imem_rvalid arriving after reset is ignored, because the FSM is in FETCH. The FSM re-requests RESET_PC.

Test Plan:
- Reset then a 1-cycle-latency memory returning 32'h00B50533 (add):
  - imem_req at cycle 1 with addr 0.
  - instr_valid at cycle 3, Opcode=0110011, Funct=4'b0000, PC_out=0.
  - Next request addr 4.
- Memory returns 32'h40B50533 (sub) at addr 4 → Funct=4'b1000, Opcode=0110011, illegal_instr=0.
- 32'h00053283 (ld x5,0(x10)) returned after 5-cycle latency:
  - No re-request during WAIT.
  - Opcode=0000011, Funct=4'b0011.
- 32'h00000063 (beq) at PC 8, with stall=1 for 4 cycles and branch_taken=1, branch_target=64'h103:
  - Outputs stable during the stall; branch ignored while stalled.
  - On stall release, next imem_addr=64'h100.
- Word 32'h0000007F → illegal_instr=1 with instr_valid=1; the following fetch proceeds at PC+4.
- Assert reset during WAIT, then pulse imem_rvalid one cycle after release:
  - Pulse ignored, outputs at reset values.
  - Request reissued at RESET_PC.
